// File: rtl/mult_ctrl_pkg.sv
// Shared constants and result record for the multiplier issue controller.
package mult_ctrl_pkg;

   // Fixed latency of the shared pipelined multiplier.
   localparam int MULT_LAT = 4;
   // Physical-register tag width.
   localparam int TAG_W    = 6;

   // One completed multiply waiting for the CDB.
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [63:0]      value;
   } mult_res_t;

endpackage

// File: rtl/mult_res_fifo.sv
// Small result FIFO holding completed multiplies until the CDB accepts them.
// A push while full is dropped (the caller flags it); a pop while empty is ignored.
module mult_res_fifo
   import mult_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         push,
   input  mult_res_t                    push_data,
   input  logic                         pop,
   output logic                         head_valid,
   output mult_res_t                    head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   mult_res_t        mem_q [DEPTH];
   mult_res_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_s, do_pop_s;

   // Pointer advance with explicit wrap so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Next-state for storage, pointers and occupancy; clear wins over push/pop.
   always_comb begin
      do_push_s = push && (count_q != CNT_W'(DEPTH));
      do_pop_s  = pop && (count_q != '0);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO state registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Head is forced to zero when empty so stale data never reaches the CDB.
   assign head_valid = (count_q != '0);
   assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
   assign count      = count_q;

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue scheduler for the shared pipelined multiplier: round-robin arbitration,
// tag shadow pipeline alongside the untagged multiplier, and a credit-limited
// result FIFO feeding the CDB.
module mult_issue_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int RES_DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*64-1:0]    req_opa,
   input  logic [NUM_REQ*64-1:0]    req_opb,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   input  logic                     flush,
   output logic                     mult_start,
   output logic [63:0]              mult_mcand,
   output logic [63:0]              mult_mplier,
   input  logic [63:0]              mult_product,
   input  logic                     mult_done,
   output logic                     cdb_req,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [63:0]              cdb_value,
   input  logic                     cdb_gnt,
   output logic                     err
);

   localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(RES_DEPTH + 1);
   localparam int SUM_W = $clog2(MULT_LAT + RES_DEPTH + 1);
   localparam int LAST  = MULT_LAT - 1;

   logic [RR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [RR_W-1:0]     cand_s, gnt_idx_s;
   logic                gnt_found_s;
   logic [TAG_W-1:0]    gnt_tag_s;
   logic [MULT_LAT-1:0] occ_q, occ_d;
   logic [MULT_LAT-1:0] live_q, live_d;
   logic [TAG_W-1:0]    tag_q [MULT_LAT];
   logic [TAG_W-1:0]    tag_d [MULT_LAT];
   logic                err_q, err_d;
   logic [SUM_W-1:0]    inflight_s;
   logic                can_issue_s;
   logic                push_s, pop_s;
   mult_res_t           push_data_s;
   logic                fifo_head_valid_s;
   mult_res_t           fifo_head_s;
   logic [CNT_W-1:0]    fifo_count_s;

   // Credit check from registered counts; held idle while reset is asserted.
   always_comb begin
      inflight_s = '0;
      for (int s = 0; s < MULT_LAT; s++) begin
         inflight_s = inflight_s + SUM_W'(live_q[s]);
      end
      can_issue_s = reset && ((inflight_s + SUM_W'(fifo_count_s)) < SUM_W'(RES_DEPTH));
   end

   // Round-robin search from rr_ptr upward with wrap; first valid requester wins.
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = '0;
      cand_s      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s = RR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (can_issue_s && !flush && !gnt_found_s && req_valid[cand_s]) begin
            gnt_found_s = 1'b1;
            gnt_idx_s   = cand_s;
         end else begin
            gnt_found_s = gnt_found_s;
         end
      end
   end

   // One-hot grant, operand/tag mux from the winner, and pointer advance.
   always_comb begin
      req_ready   = '0;
      mult_mcand  = 64'd0;
      mult_mplier = 64'd0;
      gnt_tag_s   = '0;
      rr_ptr_d    = rr_ptr_q;
      if (gnt_found_s) begin
         req_ready[gnt_idx_s] = 1'b1;
         mult_mcand           = req_opa[int'(gnt_idx_s)*64 +: 64];
         mult_mplier          = req_opb[int'(gnt_idx_s)*64 +: 64];
         gnt_tag_s            = req_tag[int'(gnt_idx_s)*TAG_W +: TAG_W];
         rr_ptr_d             = (gnt_idx_s == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + RR_W'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   assign mult_start = |(req_valid & req_ready);

   // Shadow pipeline shift; flush kills live bits but keeps occ for done checking.
   always_comb begin
      occ_d[0]  = mult_start;
      live_d[0] = mult_start;
      tag_d[0]  = gnt_tag_s;
      for (int s = 1; s < MULT_LAT; s++) begin
         occ_d[s]  = occ_q[s-1];
         live_d[s] = flush ? 1'b0 : live_q[s-1];
         tag_d[s]  = tag_q[s-1];
      end
   end

   // Completion: push live results, drop squashed ones, flag protocol errors.
   always_comb begin
      push_s      = mult_done && live_q[LAST] && !flush;
      pop_s       = fifo_head_valid_s && cdb_gnt && !flush;
      push_data_s = {tag_q[LAST], mult_product};
      err_d       = err_q
                  | (mult_done != occ_q[LAST])
                  | (push_s && (fifo_count_s == CNT_W'(RES_DEPTH)));
   end

   // Arbiter pointer, shadow pipeline and sticky error registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q <= '0;
         occ_q    <= '0;
         live_q   <= '0;
         for (int s = 0; s < MULT_LAT; s++) begin
            tag_q[s] <= '0;
         end
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         occ_q    <= occ_d;
         live_q   <= live_d;
         tag_q    <= tag_d;
         err_q    <= err_d;
      end
   end

   mult_res_fifo #(
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clock      (clock),
      .reset      (reset),
      .clear      (flush),
      .push       (push_s),
      .push_data  (push_data_s),
      .pop        (pop_s),
      .head_valid (fifo_head_valid_s),
      .head_data  (fifo_head_s),
      .count      (fifo_count_s)
   );

   assign cdb_req   = fifo_head_valid_s;
   assign cdb_tag   = fifo_head_s.tag;
   assign cdb_value = fifo_head_s.value;
   assign err       = err_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: a transaction-level model (queues of in-flight ops
// and buffered results) checked every cycle, plus directed literal checks.
module tb_mult_issue_ctrl;
   import mult_ctrl_pkg::*;

   localparam int N = 3;
   localparam int D = 4;

   logic                 clock;
   logic                 reset;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [N*64-1:0]      req_opa;
   logic [N*64-1:0]      req_opb;
   logic [N*TAG_W-1:0]   req_tag;
   logic                 flush;
   logic                 mult_start;
   logic [63:0]          mult_mcand;
   logic [63:0]          mult_mplier;
   logic [63:0]          mult_product;
   logic                 mult_done;
   logic                 cdb_req;
   logic [TAG_W-1:0]     cdb_tag;
   logic [63:0]          cdb_value;
   logic                 cdb_gnt;
   logic                 err;
   logic                 inj_done;

   int n_checks;
   int n_errors;

   mult_issue_ctrl #(.NUM_REQ(N), .RES_DEPTH(D)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_opa(req_opa), .req_opb(req_opb), .req_tag(req_tag), .flush(flush),
      .mult_start(mult_start), .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
      .mult_product(mult_product), .mult_done(mult_done), .cdb_req(cdb_req),
      .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_gnt(cdb_gnt), .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural pipelined multiplier, reset by the same net.
   logic [MULT_LAT-1:0] ms_v;
   logic [63:0]         ms_a [MULT_LAT];
   logic [63:0]         ms_b [MULT_LAT];
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         ms_v <= '0;
         for (int i = 0; i < MULT_LAT; i++) begin
            ms_a[i] <= 64'd0;
            ms_b[i] <= 64'd0;
         end
      end else begin
         ms_v    <= {ms_v[MULT_LAT-2:0], mult_start};
         ms_a[0] <= mult_mcand;
         ms_b[0] <= mult_mplier;
         for (int i = 1; i < MULT_LAT; i++) begin
            ms_a[i] <= ms_a[i-1];
            ms_b[i] <= ms_b[i-1];
         end
      end
   end
   assign mult_done    = ms_v[MULT_LAT-1] | inj_done;
   assign mult_product = ms_v[MULT_LAT-1] ? ms_a[MULT_LAT-1] * ms_b[MULT_LAT-1] : 64'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state.
   typedef struct {
      int               due;
      logic [TAG_W-1:0] tag;
      logic [63:0]      val;
      bit               live;
   } op_t;
   op_t       fly_q [$];
   mult_res_t res_q [$];
   int        m_rr;
   int        m_cyc;
   bit        m_err;

   // Per-cycle compare against the model, then advance the model across the edge.
   always @(negedge clock) begin : model_p
      int           live_cnt;
      int           g;
      bit           can, due_now, push, pop, full;
      logic [N-1:0] exp_rdy;
      logic [63:0]  exp_a, exp_b;
      mult_res_t    r;
      if (!reset) begin
         fly_q.delete();
         res_q.delete();
         m_rr  = 0;
         m_cyc = 0;
         m_err = 1'b0;
         chk("rst_req_ready", 64'(req_ready), 64'd0);
         chk("rst_mult_start", 64'(mult_start), 64'd0);
         chk("rst_mcand", mult_mcand, 64'd0);
         chk("rst_cdb_req", 64'(cdb_req), 64'd0);
         chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
         chk("rst_cdb_value", cdb_value, 64'd0);
         chk("rst_err", 64'(err), 64'd0);
      end else begin
         live_cnt = 0;
         foreach (fly_q[i]) if (fly_q[i].live) live_cnt++;
         can = (live_cnt + res_q.size()) < D;
         g = -1;
         if (can && !flush) begin
            for (int k = 0; k < N; k++) begin
               if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
         end
         exp_rdy = '0;
         exp_a   = 64'd0;
         exp_b   = 64'd0;
         if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            exp_a = req_opa[g*64 +: 64];
            exp_b = req_opb[g*64 +: 64];
         end
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("mult_start", 64'(mult_start), 64'(g >= 0));
         chk("mult_mcand", mult_mcand, exp_a);
         chk("mult_mplier", mult_mplier, exp_b);
         chk("cdb_req", 64'(cdb_req), 64'(res_q.size() != 0));
         if (res_q.size() != 0) begin
            chk("cdb_tag", 64'(cdb_tag), 64'(res_q[0].tag));
            chk("cdb_value", cdb_value, res_q[0].value);
         end else begin
            chk("cdb_tag_idle", 64'(cdb_tag), 64'd0);
            chk("cdb_value_idle", cdb_value, 64'd0);
         end
         chk("err", 64'(err), 64'(m_err));

         due_now = (fly_q.size() != 0) && (fly_q[0].due == m_cyc);
         if (mult_done !== due_now) m_err = 1'b1;
         push = due_now && mult_done && fly_q[0].live && !flush;
         pop  = (res_q.size() != 0) && cdb_gnt && !flush;
         full = res_q.size() >= D;
         r.tag   = '0;
         r.value = 64'd0;
         if (due_now) begin
            r.tag   = fly_q[0].tag;
            r.value = fly_q[0].val;
            void'(fly_q.pop_front());
         end
         if (flush) begin
            res_q.delete();
            foreach (fly_q[i]) fly_q[i].live = 1'b0;
         end else begin
            if (pop) void'(res_q.pop_front());
            if (push) begin
               if (full) m_err = 1'b1;
               else res_q.push_back(r);
            end
         end
         if (g >= 0) begin
            fly_q.push_back('{due: m_cyc + MULT_LAT, tag: req_tag[g*TAG_W +: TAG_W],
                              val: req_opa[g*64 +: 64] * req_opb[g*64 +: 64], live: 1'b1});
            m_rr = (g + 1) % N;
         end
         m_cyc++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr_inputs();
      req_valid = '0;
      req_opa   = '0;
      req_opb   = '0;
      req_tag   = '0;
      flush     = 1'b0;
      cdb_gnt   = 1'b0;
      inj_done  = 1'b0;
   endtask

   // Leaves the caller at the drive point of cycle 0 after release.
   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [TAG_W-1:0] t);
      req_opa[i*64 +: 64]       = a;
      req_opb[i*64 +: 64]       = b;
      req_tag[i*TAG_W +: TAG_W] = t;
   endtask

   task automatic drain();
      req_valid = '0;
      cdb_gnt   = 1'b1;
      repeat (12) tick();
      cdb_gnt   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main_p
      int          gcount, rcount, starts;
      logic [N-1:0] exp_g;
      n_checks = 0;
      n_errors = 0;
      clr_inputs();
      reset = 1'b1;
      #2;
      do_reset();

      // 1: single op from requester 1, 7*6 with tag 5.
      req_valid = 3'b010;
      set_op(1, 64'd7, 64'd6, 6'd5);
      #1;
      chk("t1_ready", 64'(req_ready), 64'h2);
      chk("t1_start", 64'(mult_start), 64'd1);
      tick();
      req_valid = '0;
      repeat (4) tick();
      chk("t1_cdb_req", 64'(cdb_req), 64'd1);
      chk("t1_cdb_tag", 64'(cdb_tag), 64'd5);
      chk("t1_cdb_value", cdb_value, 64'd42);
      cdb_gnt = 1'b1;
      tick();
      cdb_gnt = 1'b0;
      chk("t1_popped", 64'(cdb_req), 64'd0);
      drain();

      // 2: all requesters valid until six grants, CDB always granting.
      clr_inputs();
      do_reset();
      cdb_gnt = 1'b1;
      gcount  = 0;
      rcount  = 0;
      for (int c = 0; c < 40; c++) begin
         req_valid = (gcount < 6) ? 3'b111 : 3'b000;
         for (int i = 0; i < N; i++) begin
            set_op(i, 64'(c * 3 + i + 1), 64'(i + 2), TAG_W'(10 + i));
         end
         #1;
         if (mult_start) begin
            exp_g = 3'b001 << (gcount % 3);
            chk("t2_order", 64'(req_ready), 64'(exp_g));
            gcount++;
         end
         if (cdb_req && cdb_gnt) begin
            chk("t2_res_tag", 64'(cdb_tag), 64'(10 + (rcount % 3)));
            rcount++;
         end
         tick();
      end
      chk("t2_grants", 64'(gcount), 64'd6);
      chk("t2_results", 64'(rcount), 64'd6);
      drain();

      // 3: CDB stalled, continuous requests, credit limit.
      clr_inputs();
      do_reset();
      req_valid = 3'b111;
      for (int i = 0; i < N; i++) set_op(i, 64'(i + 3), 64'(5), TAG_W'(20 + i));
      starts = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (mult_start) starts++;
         tick();
      end
      chk("t3_issues", 64'(starts), 64'd4);
      chk("t3_blocked", 64'(req_ready), 64'd0);
      chk("t3_cdb_req", 64'(cdb_req), 64'd1);
      cdb_gnt = 1'b1;
      #1;
      chk("t3_no_reuse", 64'(req_ready), 64'd0);
      tick();
      cdb_gnt = 1'b0;
      chk("t3_resume", 64'(req_ready), 64'h2);
      chk("t3_resume_start", 64'(mult_start), 64'd1);
      tick();
      drain();

      // 4: two issues squashed by flush, then a fresh issue completes.
      clr_inputs();
      do_reset();
      req_valid = 3'b001;
      set_op(0, 64'd3, 64'd3, 6'd20);
      #1;
      chk("t4_g0", 64'(req_ready), 64'h1);
      tick();
      req_valid = 3'b010;
      set_op(1, 64'd4, 64'd4, 6'd21);
      #1;
      chk("t4_g1", 64'(req_ready), 64'h2);
      tick();
      req_valid = 3'b100;
      set_op(2, 64'd5, 64'd5, 6'd22);
      flush = 1'b1;
      #1;
      chk("t4_flush_nogrant", 64'(req_ready), 64'd0);
      tick();
      flush = 1'b0;
      set_op(2, 64'd9, 64'd8, 6'd23);
      #1;
      chk("t4_g3", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      for (int c = 4; c < 8; c++) begin
         #1;
         chk("t4_no_cdb", 64'(cdb_req), 64'd0);
         tick();
      end
      chk("t4_cdb_req", 64'(cdb_req), 64'd1);
      chk("t4_cdb_tag", 64'(cdb_tag), 64'd23);
      chk("t4_cdb_value", cdb_value, 64'd72);
      chk("t4_err", 64'(err), 64'd0);
      drain();

      // 5: spurious mult_done sets a sticky error cleared only by reset.
      clr_inputs();
      do_reset();
      tick();
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      chk("t5_err_set", 64'(err), 64'd1);
      repeat (3) tick();
      chk("t5_err_sticky", 64'(err), 64'd1);
      do_reset();
      chk("t5_err_cleared", 64'(err), 64'd0);

      // 6: reset with operations in flight and buffered.
      clr_inputs();
      tick();
      req_valid = 3'b001;
      for (int c = 0; c < 6; c++) begin
         set_op(0, 64'(11 + c), 64'd13, TAG_W'(30 + c));
         tick();
      end
      chk("t6_buffered", 64'(cdb_req), 64'd1);
      reset = 1'b0;
      #1;
      chk("t6_rst_ready", 64'(req_ready), 64'd0);
      chk("t6_rst_start", 64'(mult_start), 64'd0);
      chk("t6_rst_cdb_req", 64'(cdb_req), 64'd0);
      chk("t6_rst_cdb_value", cdb_value, 64'd0);
      chk("t6_rst_err", 64'(err), 64'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("t6_full_credit", 64'(mult_start), 64'd1);
         chk("t6_no_stale_cdb", 64'(cdb_req), 64'd0);
         tick();
      end
      chk("t6_credit_spent", 64'(mult_start), 64'd0);
      drain();

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
